// File: rtl/dla_dot_ctrl.sv
// dla_dot_ctrl: per-command sequencer for the 8-lane dot-product datapath.
// Streams operand beats, tracks datapath latency with a tag pipe, and accumulates the beat sums.
module dla_dot_ctrl #(
  parameter int MAC_LAT = 3,
  parameter int LEN_W   = 8,
  parameter int ACC_W   = 48
) (
  input  logic             dla_core_clk,
  input  logic             dla_reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     a_vec,
  input  logic [127:0]     b_vec,
  output logic [127:0]     mac_a,
  output logic [127:0]     mac_b,
  input  logic [34:0]      result_top,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_ovf
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, sent_q, sent_d, rcv_q, rcv_d;
  logic [ACC_W-1:0] acc_q, acc_d, addend, sum;
  logic ovf_q, ovf_d, accept, fire;
  logic [127:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d;
  logic [MAC_LAT-1:0] tag_q, tag_d;
  logic [MAC_LAT:0] tag_ext;
  assign in_ready  = state_q == LOAD;
  assign busy      = state_q != IDLE;
  assign res_valid = state_q == DONE;
  assign res_data  = acc_q;
  assign res_ovf   = ovf_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign accept    = in_ready && in_valid;
  assign fire      = tag_q[MAC_LAT-1];
  assign addend    = ACC_W'($signed(result_top));
  assign sum       = acc_q + addend;
  // one extra bit keeps the shift expressible when MAC_LAT is 1
  assign tag_ext   = {tag_q, accept};
  assign tag_d     = tag_ext[MAC_LAT-1:0];
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sent_d  = sent_q;
    rcv_d   = fire ? rcv_q + LEN_W'(1) : rcv_q;
    acc_d   = fire ? sum : acc_q;
    ovf_d   = ovf_q | (fire && acc_q[ACC_W-1] == addend[ACC_W-1] && sum[ACC_W-1] != acc_q[ACC_W-1]);
    mac_a_d = accept ? a_vec : '0;
    mac_b_d = accept ? b_vec : '0;
    case (state_q)
      IDLE: if (start) begin
        len_d   = len;
        sent_d  = '0;
        rcv_d   = '0;
        acc_d   = '0;
        ovf_d   = 1'b0;
        state_d = len == '0 ? DONE : LOAD;
      end
      LOAD: if (accept) begin
        sent_d  = sent_q + LEN_W'(1);
        state_d = sent_d == len_q ? DRAIN : LOAD;
      end
      DRAIN: state_d = rcv_q == len_q ? DONE : DRAIN;
      DONE: state_d = res_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge dla_core_clk) begin
    if (!dla_reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      sent_q  <= '0;
      rcv_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      mac_a_q <= '0;
      mac_b_q <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sent_q  <= sent_d;
      rcv_q   <= rcv_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      mac_a_q <= mac_a_d;
      mac_b_q <= mac_b_d;
      tag_q   <= tag_d;
    end
  end
endmodule

// File: tb/tb_dla_dot_ctrl.sv
// tb_dla_dot_ctrl: drives a 48-bit and a 36-bit controller with identical stimulus,
// models the datapath, and checks results against an arithmetic reference.
module tb_dla_dot_ctrl;
  localparam int LAT = 3;
  typedef struct {
    int n;
    logic [15:0] a;
    logic [15:0] b;
    int gap;
    int hold;
    bit pulse;
    longint exp;
    bit ovf36;
  } vec_t;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, res_ready = 0;
  logic [7:0] len = 0;
  logic [127:0] a_vec = 0, b_vec = 0;
  logic [127:0] mac_a, mac_b, mac_a36, mac_b36;
  logic [34:0] rt, rt36;
  logic [34:0] pa [LAT-1];
  logic [34:0] pb [LAT-1];
  logic busy, in_ready, res_valid, res_ovf, busy36, in_ready36, res_valid36, res_ovf36;
  logic [47:0] res_data;
  logic [35:0] res_data36;
  logic [127:0] av [16];
  logic [127:0] bv [16];
  vec_t tab [7];
  int nchk = 0, errs = 0;

  always #5 clk = ~clk;

  dla_dot_ctrl #(.MAC_LAT(LAT), .LEN_W(8), .ACC_W(48)) u_dut (
    .dla_core_clk(clk), .dla_reset(rst_n), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
    .mac_a(mac_a), .mac_b(mac_b), .result_top(rt), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf));

  dla_dot_ctrl #(.MAC_LAT(LAT), .LEN_W(8), .ACC_W(36)) u_dut36 (
    .dla_core_clk(clk), .dla_reset(rst_n), .start(start), .len(len), .busy(busy36),
    .in_valid(in_valid), .in_ready(in_ready36), .a_vec(a_vec), .b_vec(b_vec),
    .mac_a(mac_a36), .mac_b(mac_b36), .result_top(rt36), .res_valid(res_valid36),
    .res_ready(res_ready), .res_data(res_data36), .res_ovf(res_ovf36));

  function automatic logic [34:0] dot(input logic [127:0] a, input logic [127:0] b);
    longint s = 0;
    for (int i = 0; i < 8; i++) s += longint'($signed(a[16*i+:16])) * longint'($signed(b[16*i+:16]));
    return 35'(s);
  endfunction

  // datapath stand-in: mac_a/mac_b register counts as the first of LAT stages
  always @(posedge clk) begin
    pa[0] <= dot(mac_a, mac_b);
    pb[0] <= dot(mac_a36, mac_b36);
    for (int k = 1; k < LAT - 1; k++) begin
      pa[k] <= pa[k-1];
      pb[k] <= pb[k-1];
    end
  end
  assign rt   = pa[LAT-2];
  assign rt36 = pb[LAT-2];

  function automatic void model(input int n, input int w, output longint acc, output bit ovf);
    longint lim = longint'(1) << (w - 1);
    acc = 0;
    ovf = 0;
    for (int i = 0; i < n; i++) begin
      acc += longint'($signed(dot(av[i], bv[i])));
      if (acc >= lim) begin acc -= 2 * lim; ovf = 1; end
      else if (acc < -lim) begin acc += 2 * lim; ovf = 1; end
    end
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run(input int n, input int gap, input int hold, input bit junk, input bit pulse,
                     input bit use_tab, input longint tab_exp, input bit tab_ovf36);
    longint e48, e36;
    bit o48, o36, acc_prev, seen;
    int cyc, idx, gcnt;
    model(n, 48, e48, o48);
    model(n, 36, e36, o36);
    @(negedge clk);
    start = 1; len = 8'(n); in_valid = 0;
    cyc = 0; idx = 0; gcnt = 0; acc_prev = 0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 0;
      if (acc_prev) begin idx++; gcnt = gap; end
      if (cyc == 1) chk("busy_after_start", busy, 1);
      if (res_valid) break;
      if (!acc_prev && in_ready && cyc > 1) chk("mac_a_idle_zero", longint'(mac_a == 0), 1);
      if (pulse && cyc == 2) begin start = 1; len = 8'd7; end
      if (idx < n && gcnt == 0) begin
        in_valid = 1; a_vec = av[idx]; b_vec = bv[idx];
      end else begin
        if (gcnt > 0) gcnt--;
        in_valid = junk && idx >= n;
        a_vec = junk ? {$urandom, $urandom, $urandom, $urandom} : '0;
        b_vec = junk ? {$urandom, $urandom, $urandom, $urandom} : '0;
      end
      acc_prev = in_valid && in_ready;
    end
    in_valid = 0; a_vec = 0; b_vec = 0;
    chk("latency", cyc, n == 0 ? 1 : 2 + n + LAT + gap * (n - 1));
    chk("res_data48", longint'($signed(res_data)), e48);
    chk("res_ovf48", res_ovf, longint'(o48));
    chk("res_data36", longint'($signed(res_data36)), e36);
    chk("res_ovf36", res_ovf36, longint'(o36));
    if (use_tab) begin
      chk("tab_data48", longint'($signed(res_data)), tab_exp);
      chk("tab_ovf36", res_ovf36, longint'(tab_ovf36));
    end
    res_ready = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_data", longint'($signed(res_data)), e48);
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk("valid_drop", res_valid, 0);
    chk("idle_busy", busy, 0);
    if (pulse) begin
      seen = 0;
      repeat (12) begin @(negedge clk); seen |= res_valid; end
      chk("single_result", seen, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    tab[0] = '{4, 16'h0001, 16'h0002, 0, 0, 0, 64'sd64, 0};
    tab[1] = '{1, 16'hFFFF, 16'h0003, 0, 0, 0, -64'sd24, 0};
    tab[2] = '{3, 16'h0002, 16'h0001, 2, 0, 0, 64'sd48, 0};
    tab[3] = '{0, 16'h0000, 16'h0000, 0, 0, 0, 64'sd0, 0};
    tab[4] = '{2, 16'h0003, 16'h0004, 0, 10, 1, 64'sd192, 0};
    tab[5] = '{5, 16'h7FFF, 16'h7FFF, 0, 0, 0, 64'sd42947051560, 1};
    tab[6] = '{4, 16'h7FFF, 16'h7FFF, 0, 0, 0, 64'sd34357641248, 0};
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_ovf", res_ovf, 0);
    chk("rst_mac_a", longint'(mac_a == 0), 1);
    rst_n = 1;
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < tab[i].n; j++) begin
        av[j] = {8{tab[i].a}};
        bv[j] = {8{tab[i].b}};
      end
      run(tab[i].n, tab[i].gap, tab[i].hold, 0, tab[i].pulse, 1, tab[i].exp, tab[i].ovf36);
    end
    // reset after two of four beats: the command is discarded
    for (int j = 0; j < 4; j++) begin
      av[j] = {$urandom, $urandom, $urandom, $urandom};
      bv[j] = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk); start = 1; len = 8'd4;
    @(negedge clk); start = 0; in_valid = 1; a_vec = av[0]; b_vec = bv[0];
    @(negedge clk); a_vec = av[1]; b_vec = bv[1];
    @(negedge clk); rst_n = 0; in_valid = 0; a_vec = 0; b_vec = 0;
    @(negedge clk); rst_n = 1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_mac_a", longint'(mac_a == 0), 1);
    seen = 0;
    repeat (8) begin @(negedge clk); seen |= res_valid | busy; end
    chk("mid_rst_quiet", seen, 0);
    av[0] = {$urandom, $urandom, $urandom, $urandom};
    bv[0] = {$urandom, $urandom, $urandom, $urandom};
    run(1, 0, 0, 0, 0, 0, 0, 0);
    for (int r = 0; r < 25; r++) begin
      int n;
      n = $urandom_range(0, 12);
      for (int j = 0; j < n; j++) begin
        av[j] = {$urandom, $urandom, $urandom, $urandom};
        bv[j] = {$urandom, $urandom, $urandom, $urandom};
      end
      run(n, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, 0, 0, 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule

// File: doc/dla_dot_ctrl.md
Name: dla_dot_ctrl

Overview:
Sequencer for the 8-lane dot-product datapath (two 4-input MAC instances summed into a 35-bit result) in the DLA core. It runs one dot product per command. It accepts a beat count, streams that many 8-lane operand beats into the datapath with a valid/ready handshake, and tracks the datapath pipeline latency with a tag shift register. It accumulates each 35-bit beat result into a wide signed accumulator and returns the final sum on a valid/ready result port.

Parameters:
MAC_LAT, 3, cycles from operands on mac_a/mac_b (registered) to corresponding result_top; must be >= 1
LEN_W, 8, width of beat-count command
ACC_W, 48, accumulator/result width (signed); must be >= 35

Ports:
dla_core_clk  input  1  core clock, all logic on rising edge
dla_reset  input  1  synchronous reset, active-low
start  input  1  command strobe, sampled only in IDLE
len  input  LEN_W  number of 8-lane beats in this dot product
busy  output  1  high in any state other than IDLE
in_valid  input  1  operand beat valid
in_ready  output  1  controller accepts operand beat
a_vec  input  128  lane i (signed 16-bit) at [16i+15:16i]; lane 0 feeds dataa_in1 ... lane 7 feeds dataa_in8
b_vec  input  128  same packing, feeds datab_in1..8
mac_a  output  128  registered operands to datapath A inputs
mac_b  output  128  registered operands to datapath B inputs
result_top  input  35  signed datapath sum
res_valid  output  1  final result available
res_ready  input  1  consumer accepts result
res_data  output  ACC_W  signed dot-product result
res_ovf  output  1  accumulator signed overflow occurred during this command

Behaviour:
- Reset (dla_reset==0 at an edge) has priority over everything and may occur in any state:
  - state=IDLE.
  - Clear: in_ready, res_valid, res_ovf, res_data, mac_a, mac_b, beat counters, accumulator, tag pipe.
  - Any in-flight command is discarded.
- States:
  - IDLE:
    - start==1 and len!=0: latch len, clear acc/ovf/counters, go LOAD.
    - start==1 and len==0: go DONE with res_data=0, res_ovf=0.
    - start==0: stay.
  - LOAD: in_ready=1 (combinational from state).
    - On in_valid&in_ready: mac_a<=a_vec, mac_b<=b_vec, tag[0]<=1, sent_cnt+1.
    - On cycles with no accept: mac_a/mac_b<=0, tag[0]<=0.
    - When the accept makes sent_cnt==len, go DRAIN. in_ready is low from the next cycle.
  - DRAIN: in_ready=0, mac_a/mac_b<=0. When rcv_cnt==len, go DONE.
  - DONE: res_valid=1 and res_data/res_ovf are stable.
    - On res_ready==1: go IDLE; res_valid is low the next cycle.
    - res_ready is ignored outside DONE.
- Tag pipe:
  - Shift register of MAC_LAT bits, shifting every cycle.
  - At any edge where tag[MAC_LAT-1]==1: acc <= acc + sign-extend(result_top), and rcv_cnt+1.
  - Accumulation also occurs during LOAD, overlapping new accepts.
- Arithmetic:
  - Accumulation wraps two's complement in ACC_W bits.
  - res_ovf is set sticky when both operands have the same sign and the sum's sign differs.
- start is ignored while busy; no queueing.
- Latency from start to res_valid:
  - len==0: 1 cycle.
  - Otherwise: 1 + len + MAC_LAT + 1 cycles with in_valid held high.
  - Each in_valid gap adds its length.
- in_valid outside LOAD: ignored; no beat is consumed.

Test Plan:
- Basic: MAC_LAT=3. a lanes all 1, b lanes all 2, len=4, in_valid held high -> res_valid asserted 9 cycles after start, res_data=64, res_ovf=0.
- Signed: len=1, a lanes 0xFFFF (-1), b lanes 3 -> res_data=-24 (all ones above bit 4 pattern 0x...FFE8).
- Gaps: len=3, beats of 16 each, in_valid low for 2 cycles between each beat -> res_data=48, and mac_a reads 0 during the gaps. Check that exactly 3 accumulations occur (rcv_cnt).
- Zero length and busy: len=0 start -> res_valid next cycle with res_data=0. Second case: start pulsed during LOAD of a len=2 command -> ignored; one result only.
- Backpressure and overflow:
  - Hold res_ready low 10 cycles in DONE -> res_valid and res_data stable.
  - With ACC_W=36, len=5, all lanes 0x7FFF -> res_ovf=1.
  - With ACC_W=36, len=4 -> res_ovf=0.
- Reset mid-operation: assert dla_reset low for 1 cycle in LOAD after 2 of 4 beats -> IDLE, busy=0, no res_valid. A new len=1 command afterwards returns only its own beat sum.
